// File: rtl/read_count_pkg.sv
// read_count_pkg: widths, sequencer state codes and JVM opcode constants for the operand-byte counter
package read_count_pkg;
    localparam int PARAM_LEN = 3;
    localparam int SMNL = 4;
    localparam logic [SMNL-1:0] ST_FETCH = SMNL'(1);
    localparam logic [SMNL-1:0] ST_PARAM = SMNL'(2);
    localparam logic [7:0] OP_BIPUSH = 8'h10;
    localparam logic [7:0] OP_SIPUSH = 8'h11;
    localparam logic [7:0] OP_LDC = 8'h12;
    localparam logic [7:0] OP_LDC_W = 8'h13;
    localparam logic [7:0] OP_LDC2_W = 8'h14;
    localparam logic [7:0] OP_ILOAD = 8'h15;
    localparam logic [7:0] OP_ALOAD = 8'h19;
    localparam logic [7:0] OP_ISTORE = 8'h36;
    localparam logic [7:0] OP_ASTORE = 8'h3a;
    localparam logic [7:0] OP_IINC = 8'h84;
    localparam logic [7:0] OP_IFEQ = 8'h99;
    localparam logic [7:0] OP_JSR = 8'ha8;
    localparam logic [7:0] OP_RET = 8'ha9;
    localparam logic [7:0] OP_TABLESWITCH = 8'haa;
    localparam logic [7:0] OP_LOOKUPSWITCH = 8'hab;
    localparam logic [7:0] OP_GETSTATIC = 8'hb2;
    localparam logic [7:0] OP_INVOKESTATIC = 8'hb8;
    localparam logic [7:0] OP_INVOKEINTERFACE = 8'hb9;
    localparam logic [7:0] OP_INVOKEDYNAMIC = 8'hba;
    localparam logic [7:0] OP_NEW = 8'hbb;
    localparam logic [7:0] OP_NEWARRAY = 8'hbc;
    localparam logic [7:0] OP_ANEWARRAY = 8'hbd;
    localparam logic [7:0] OP_CHECKCAST = 8'hc0;
    localparam logic [7:0] OP_INSTANCEOF = 8'hc1;
    localparam logic [7:0] OP_WIDE = 8'hc4;
    localparam logic [7:0] OP_MULTIANEWARRAY = 8'hc5;
    localparam logic [7:0] OP_IFNULL = 8'hc6;
    localparam logic [7:0] OP_IFNONNULL = 8'hc7;
    localparam logic [7:0] OP_GOTO_W = 8'hc8;
    localparam logic [7:0] OP_JSR_W = 8'hc9;
endpackage

// File: rtl/read_count_oplen_decode.sv
// jvm_oplen_decode: combinational opcode -> fixed operand length (op[7:0] in, len[2:0] out; switch/wide/reserved give 0)
module jvm_oplen_decode
    import read_count_pkg::*;
(
    input  logic [7:0] op,
    output logic [2:0] len
);
    always_comb begin
        len = 3'd0;
        case (op) inside
            OP_BIPUSH, OP_LDC, [OP_ILOAD:OP_ALOAD], [OP_ISTORE:OP_ASTORE], OP_RET, OP_NEWARRAY:
                len = 3'd1;
            OP_SIPUSH, OP_LDC_W, OP_LDC2_W, OP_IINC, [OP_IFEQ:OP_JSR], [OP_GETSTATIC:OP_INVOKESTATIC],
            OP_NEW, OP_ANEWARRAY, OP_CHECKCAST, OP_INSTANCEOF, OP_IFNULL, OP_IFNONNULL:
                len = 3'd2;
            OP_MULTIANEWARRAY:
                len = 3'd3;
            OP_INVOKEINTERFACE, OP_INVOKEDYNAMIC, OP_GOTO_W, OP_JSR_W:
                len = 3'd4;
            default:
                len = 3'd0;
        endcase
    end
endmodule

// File: rtl/read_count.sv
// read_count: operand-byte counter (clk, reset active-low sync, iram_data[7:0], state[SMNL-1:0] in; count[PARAM_LEN-1:0] registered out)
module read_count
    import read_count_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           iram_data,
    input  logic [SMNL-1:0]      state,
    output logic [PARAM_LEN-1:0] count
);
    logic [2:0] len;
    logic [PARAM_LEN-1:0] load;
    jvm_oplen_decode u_dec (.op(iram_data), .len(len));
    // Size cast zero-extends or truncates; below 3 bits a length of 4 is not representable.
    assign load = PARAM_LEN'(len);
    always_ff @(posedge clk) begin
        if (!reset)
            count <= '0;
        else if (state == ST_FETCH)
            count <= load;
        else if (state == ST_PARAM && count != '0)
            count <= count - PARAM_LEN'(1);
    end
endmodule

// File: tb/tb_read_count.sv
// tb_read_count: directed self-checking bench for read_count
module tb_read_count;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [7:0] iram_data = 8'h00;
    logic [3:0] state = 4'd0;
    logic [2:0] count;
    logic [2:0] mdl = 3'd0;
    int nvec = 0;
    int nfail = 0;

    read_count dut (.clk(clk), .reset(reset), .iram_data(iram_data), .state(state), .count(count));

    always #5 clk = ~clk;

    function automatic logic [2:0] ref_len(input logic [7:0] o);
        if (o == 8'hc5) return 3'd3;
        if (o inside {8'hb9, 8'hba, 8'hc8, 8'hc9}) return 3'd4;
        if (o inside {8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3a], 8'ha9, 8'hbc}) return 3'd1;
        if (o inside {8'h11, 8'h13, 8'h14, 8'h84, [8'h99:8'ha8], [8'hb2:8'hb8], 8'hbb, 8'hbd,
                      8'hc0, 8'hc1, 8'hc6, 8'hc7}) return 3'd2;
        return 3'd0;
    endfunction

    task automatic tick(input logic r, input logic [3:0] s, input logic [7:0] d);
        @(negedge clk);
        reset = r;
        state = s;
        iram_data = d;
        @(posedge clk);
        #1;
        if (!r) mdl = 3'd0;
        else if (s == 4'd1) mdl = ref_len(d);
        else if (s == 4'd2 && mdl != 3'd0) mdl = mdl - 3'd1;
    endtask

    task automatic check(input string tag, input logic [2:0] exp);
        nvec++;
        assert (count === exp) else begin
            nfail++;
            $error("FAIL %s: count=%0d expected=%0d", tag, count, exp);
        end
    endtask

    initial begin
        tick(1'b0, 4'd1, 8'h11); check("reset", 3'd0);
        tick(1'b1, 4'd1, 8'h11); check("post_reset_fetch", 3'd2);
        for (int i = 0; i < 256; i++) begin
            tick(1'b1, 4'd1, 8'(i));
            check($sformatf("sweep_%02h", i), ref_len(8'(i)));
        end
        tick(1'b1, 4'd1, 8'h10); check("spot_10", 3'd1);
        tick(1'b1, 4'd1, 8'hb6); check("spot_b6", 3'd2);
        tick(1'b1, 4'd1, 8'hc5); check("spot_c5", 3'd3);
        tick(1'b1, 4'd1, 8'hc8); check("spot_c8", 3'd4);
        tick(1'b1, 4'd1, 8'h60); check("spot_60", 3'd0);
        tick(1'b1, 4'd1, 8'haa); check("spot_aa", 3'd0);
        tick(1'b1, 4'd1, 8'hb9); check("cd_load", 3'd4);
        tick(1'b1, 4'd2, 8'h00); check("cd_3", 3'd3);
        tick(1'b1, 4'd2, 8'h01); check("cd_2", 3'd2);
        tick(1'b1, 4'd2, 8'h02); check("cd_1", 3'd1);
        tick(1'b1, 4'd2, 8'h03); check("cd_0", 3'd0);
        tick(1'b1, 4'd2, 8'hb9); check("cd_sat", 3'd0);
        tick(1'b1, 4'd1, 8'h11); check("hold_load", 3'd2);
        tick(1'b1, 4'd5, 8'hc8); check("hold_1", 3'd2);
        tick(1'b1, 4'd0, 8'hc5); check("hold_2", 3'd2);
        tick(1'b1, 4'd15, 8'h10); check("hold_3", 3'd2);
        tick(1'b1, 4'd2, 8'h00); check("hold_dec", 3'd1);
        tick(1'b1, 4'd1, 8'hc5); check("mid_load", 3'd3);
        tick(1'b1, 4'd2, 8'h00); check("mid_dec", 3'd2);
        tick(1'b0, 4'd2, 8'h00); check("mid_reset", 3'd0);
        tick(1'b1, 4'd2, 8'h00); check("mid_after1", 3'd0);
        tick(1'b1, 4'd2, 8'h00); check("mid_after2", 3'd0);
        for (int i = 0; i < 200; i++) begin
            tick(i != 57, 4'(i), 8'(i * 37 + 5));
            check("stress", mdl);
            #2;
            state = state + 4'd1;
            iram_data = iram_data + 8'd1;
            #1;
            check("stress_nocomb", mdl);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
